// File: rtl/mprj_wb_responder.sv
// Wishbone B4 classic responder for the user-project side of the mprj_* bus.
// Exposes scratch/ctrl/status registers and two 32-bit mailbox FIFOs:
// TX carries CPU->user words, RX carries user->CPU words.
module mprj_wb_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFE0,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          WAIT_STATES = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);
  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [8:0] DEPTH_L = 9'(FIFO_DEPTH);
  localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state, state_nxt;
  logic [2:0]  wcnt, wcnt_nxt;
  logic        ack_q;
  logic [31:0] scratch;
  logic [1:0]  irq_en;        // [0] rx_irq_en, [1] tx_empty_irq_en
  logic        tx_drop;
  logic        rx_ready_q;
  logic        irq_q;
  logic [31:0] rdata;

  logic [31:0]   tx_mem [FIFO_DEPTH];
  logic [31:0]   rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [8:0]    tx_level, rx_level, tx_level_nxt, rx_level_nxt;

  logic req, bus_wr, bus_rd, fifo_clr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_try, tx_push, tx_pop, rx_push, rx_pop;
  logic [2:0] off;

  assign req      = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign off      = wbs_adr_i[4:2];
  assign tx_full  = (tx_level == DEPTH_L);
  assign tx_empty = (tx_level == 9'd0);
  assign rx_full  = (rx_level == DEPTH_L);
  assign rx_empty = (rx_level == 9'd0);

  // Side effects happen only during the ack cycle, using the live bus inputs.
  assign bus_wr      = ack_q & wbs_we_i;
  assign bus_rd      = ack_q & ~wbs_we_i;
  assign fifo_clr    = bus_wr & (off == 3'd1) & wbs_sel_i[0] & wbs_dat_i[2];
  assign tx_push_try = bus_wr & (off == 3'd3) & (wbs_sel_i == 4'hF);
  assign tx_push     = tx_push_try & ~tx_full & ~fifo_clr;
  assign tx_pop      = ~tx_empty & tx_ready & ~fifo_clr;
  assign rx_push     = rx_valid & rx_ready_q & ~fifo_clr;
  assign rx_pop      = bus_rd & (off == 3'd4) & ~rx_empty & ~fifo_clr;

  // Bus FSM next state: IDLE -> WAIT (counted) -> ACK -> IDLE; abort on cyc/stb drop.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_IDLE: if (req) begin
        if (WAIT_STATES > 0) begin
          state_nxt = S_WAIT;
          wcnt_nxt  = 3'd0;
        end else begin
          state_nxt = S_ACK;
        end
      end
      S_WAIT: begin
        if (!(wbs_cyc_i && wbs_stb_i)) state_nxt = S_IDLE;
        else if (wcnt == WS_LAST)      state_nxt = S_ACK;
        else                           wcnt_nxt  = wcnt + 3'd1;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state, wait counter and the registered ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      wcnt  <= 3'd0;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      ack_q <= (state_nxt == S_ACK);
    end
  end

  // Next FIFO levels; a clear overrides every push and pop.
  always_comb begin
    tx_level_nxt = tx_level + {8'd0, tx_push} - {8'd0, tx_pop};
    rx_level_nxt = rx_level + {8'd0, rx_push} - {8'd0, rx_pop};
    if (fifo_clr) begin
      tx_level_nxt = 9'd0;
      rx_level_nxt = 9'd0;
    end
  end

  // Control registers, sticky drop flag, FIFO pointers, rx_ready and irq.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scratch    <= 32'd0;
      irq_en     <= 2'd0;
      tx_drop    <= 1'b0;
      tx_wp      <= '0;
      tx_rp      <= '0;
      rx_wp      <= '0;
      rx_rp      <= '0;
      tx_level   <= 9'd0;
      rx_level   <= 9'd0;
      rx_ready_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (bus_wr && off == 3'd0)
        for (int b = 0; b < 4; b++)
          if (wbs_sel_i[b]) scratch[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
      if (bus_wr && off == 3'd1 && wbs_sel_i[0]) irq_en <= wbs_dat_i[1:0];
      if (fifo_clr)                                           tx_drop <= 1'b0;
      else if (tx_push_try && tx_full)                        tx_drop <= 1'b1;
      else if (bus_wr && off == 3'd2 && wbs_sel_i[3] && wbs_dat_i[24]) tx_drop <= 1'b0;
      if (fifo_clr) begin
        tx_wp <= '0;
        tx_rp <= '0;
        rx_wp <= '0;
        rx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + 1'b1;
        if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        if (rx_push) rx_wp <= rx_wp + 1'b1;
        if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
      tx_level   <= tx_level_nxt;
      rx_level   <= rx_level_nxt;
      rx_ready_q <= (rx_level_nxt != DEPTH_L);
      irq_q      <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty);
    end
  end

  // FIFO storage; stale entries are harmless because pointers gate visibility.
  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wp] <= wbs_dat_i;
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  // Read mux for the register map.
  always_comb begin
    rdata = 32'd0;
    case (off)
      3'd0: rdata = scratch;
      3'd1: rdata = {30'd0, irq_en};
      3'd2: rdata = {7'd0, tx_drop, 2'd0, rx_empty, rx_full, tx_empty, tx_full, rx_level, tx_level};
      3'd4: rdata = rx_empty ? 32'd0 : rx_mem[rx_rp];
      default: rdata = 32'd0;
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = bus_rd ? rdata : 32'd0;
  assign tx_data   = tx_mem[tx_rp];
  assign tx_valid  = ~tx_empty;
  assign rx_ready  = rx_ready_q;
  assign irq       = irq_q;
endmodule

// File: tb/tb_mprj_wb_responder.sv
// Bench for mprj_wb_responder: directed bus/stream stimulus, a queue-based
// model of the register map checked every cycle, plus literal expectations.
module tb_mprj_wb_responder;
  localparam int          WS    = 1;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 0, stb = 0, we = 0;
  logic [3:0]  sel = 0;
  logic [31:0] adr = 0, dat = 0;
  logic        ack;
  logic [31:0] dat_o, tx_data;
  logic        tx_valid, tx_ready = 0;
  logic [31:0] rx_data = 0;
  logic        rx_valid = 0, rx_ready, irq;

  always #5 clk = ~clk;

  mprj_wb_responder #(.BASE_ADDR(BASE), .ADDR_MASK(32'hFFFF_FFE0),
                      .FIFO_DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .irq(irq));

  int total = 0, bad = 0;
  bit chk_en = 0;

  // Behavioural model state
  logic [31:0] m_tx[$], m_rx[$];
  logic [31:0] m_scratch = 0;
  logic [1:0]  m_en = 0;
  logic        m_drop = 0, m_rx_ready = 0, m_irq = 0;
  logic        exp_ack = 0;   // set by the bus tasks for the cycle the ack is due

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [2:0] off);
    logic [31:0] r;
    r = 32'd0;
    case (off)
      3'd0: r = m_scratch;
      3'd1: r = {30'd0, m_en};
      3'd2: begin
        r[8:0]  = 9'(m_tx.size());
        r[17:9] = 9'(m_rx.size());
        r[18]   = (m_tx.size() == DEPTH);
        r[19]   = (m_tx.size() == 0);
        r[20]   = (m_rx.size() == DEPTH);
        r[21]   = (m_rx.size() == 0);
        r[24]   = m_drop;
      end
      3'd4: r = (m_rx.size() != 0) ? m_rx[0] : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Model update at each active edge from the pre-edge state and inputs.
  always @(posedge clk) begin : model
    int ntx, nrx;
    bit clr;
    if (rst) begin
      m_tx.delete(); m_rx.delete();
      m_scratch = 0; m_en = 0; m_drop = 0; m_rx_ready = 0; m_irq = 0;
    end else begin
      ntx = m_tx.size();
      nrx = m_rx.size();
      m_irq = (m_en[0] && nrx != 0) || (m_en[1] && ntx == 0);
      clr = exp_ack && we && adr[4:2] == 3'd1 && sel[0] && dat[2];
      if (clr) begin
        m_tx.delete(); m_rx.delete(); m_drop = 0;
      end else begin
        if (ntx != 0 && tx_ready) void'(m_tx.pop_front());
        if (exp_ack && we && adr[4:2] == 3'd3 && sel == 4'hF) begin
          if (ntx == DEPTH) m_drop = 1;
          else m_tx.push_back(dat);
        end
        if (exp_ack && !we && adr[4:2] == 3'd4 && nrx != 0) void'(m_rx.pop_front());
        if (rx_valid && m_rx_ready) m_rx.push_back(rx_data);
      end
      if (exp_ack && we) begin
        case (adr[4:2])
          3'd0: for (int b = 0; b < 4; b++) if (sel[b]) m_scratch[b*8 +: 8] = dat[b*8 +: 8];
          3'd1: if (sel[0]) m_en = dat[1:0];
          3'd2: if (sel[3] && dat[24]) m_drop = 0;
          default: ;
        endcase
      end
      m_rx_ready = (m_rx.size() != DEPTH);
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", {31'd0, ack}, {31'd0, exp_ack});
      chk("dat_o", dat_o, (exp_ack && !we) ? mread(adr[4:2]) : 32'd0);
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_tx.size() != 0});
      if (m_tx.size() != 0) chk("tx_data", tx_data, m_tx[0]);
      chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_rx_ready});
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] r);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; sel = s; dat = d;
    repeat (WS + 1) @(posedge clk);
    #1 exp_ack = 1;
    @(negedge clk);
    r = dat_o;
    @(posedge clk); #1;
    exp_ack = 0; cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] r;
    xfer(1'b1, a, s, d, r);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    xfer(1'b0, a, 4'hF, 32'd0, r);
  endtask

  initial begin
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #1 rst = 0; chk_en = 1;
    @(negedge clk) chk("rx_ready_reset", {31'd0, rx_ready}, 32'd0);
    @(negedge clk) chk("rx_ready_rise", {31'd0, rx_ready}, 32'd1);
    rd(BASE, r);             chk("scratch_reset", r, 32'd0);

    // Full and byte-lane scratch writes
    wr(BASE, 4'hF, 32'hDEAD_BEEF);
    rd(BASE, r);             chk("scratch_full", r, 32'hDEAD_BEEF);
    wr(BASE, 4'b0001, 32'h0000_00AA);
    rd(BASE, r);             chk("scratch_byte", r, 32'hDEAD_BEAA);

    // tx_empty irq enable
    wr(BASE + 32'h4, 4'hF, 32'h2);
    rd(BASE + 32'h4, r);     chk("ctrl_rd", r, 32'h2);
    @(negedge clk)           chk("irq_tx_empty", {31'd0, irq}, 32'd1);
    wr(BASE + 32'h4, 4'hF, 32'h0);

    // TX overflow, drop flag, ordered streaming
    for (int i = 0; i < 9; i++) wr(BASE + 32'hC, 4'hF, 32'h1000 + i);
    rd(BASE + 32'h8, r);     chk("status_tx_full", r, 32'h0124_0008);
    chk("tx_head", tx_data, 32'h1000);
    @(posedge clk); #1 tx_ready = 1;
    for (int i = 0; i < 8; i++) @(negedge clk) chk("tx_stream", tx_data, 32'h1000 + i);
    @(posedge clk); #1 tx_ready = 0;
    wr(BASE + 32'h8, 4'b1000, 32'h0100_0000);
    rd(BASE + 32'h8, r);     chk("status_w1c", r, 32'h0028_0000);

    // RX push, irq, drain
    wr(BASE + 32'h4, 4'hF, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 rx_valid = 1; rx_data = 32'hA0 + i;
    end
    @(posedge clk); #1 rx_valid = 0;
    rd(BASE + 32'h8, r);     chk("status_rx3", r, 32'h0008_0600);
    @(negedge clk)           chk("irq_rx", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      rd(BASE + 32'h10, r);  chk("rx_pop", r, 32'hA0 + i);
    end
    rd(BASE + 32'h10, r);    chk("rx_empty_rd", r, 32'd0);
    @(negedge clk)           chk("irq_fall", {31'd0, irq}, 32'd0);

    // Bus pop coincident with user pushes, then clear both FIFOs
    @(posedge clk); #1 rx_valid = 1; rx_data = 32'hB0;
    rd(BASE + 32'h10, r);    chk("rx_pop_push", r, 32'hB0);
    rx_valid = 0;
    wr(BASE + 32'hC, 4'hF, 32'h55);
    wr(BASE + 32'h4, 4'hF, 32'h4);
    rd(BASE + 32'h8, r);     chk("status_clr", r, 32'h0028_0000);
    rd(BASE + 32'h4, r);     chk("ctrl_clr_bit", r, 32'd0);
    rd(BASE + 32'h14, r);    chk("unmapped", r, 32'd0);

    // Abort in WAIT: no ack, no pop
    @(posedge clk); #1 rx_valid = 1; rx_data = 32'hC0;
    @(posedge clk); #1 rx_valid = 0;
    @(posedge clk); #1 cyc = 1; stb = 1; we = 0; adr = BASE + 32'h10; sel = 4'hF;
    @(posedge clk); #1 cyc = 0; stb = 0;
    repeat (3) @(posedge clk);
    rd(BASE + 32'h8, r);     chk("status_abort", r, 32'h0008_0200);

    // Non-hit address is never acked
    @(posedge clk); #1 cyc = 1; stb = 1; adr = BASE + 32'h1000;
    repeat (6) @(posedge clk);
    @(negedge clk)           chk("nohit_ack", {31'd0, ack}, 32'd0);
    @(posedge clk); #1 cyc = 0; stb = 0;

    // Reset in WAIT with TX holding 4 words
    for (int i = 0; i < 4; i++) wr(BASE + 32'hC, 4'hF, 32'h2000 + i);
    @(posedge clk); #1 cyc = 1; stb = 1; we = 0; adr = BASE; sel = 4'hF;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; cyc = 0; stb = 0;
    @(negedge clk)           chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    rd(BASE + 32'h8, r);     chk("status_after_rst", r, 32'h0028_0000);
    rd(BASE, r);             chk("scratch_after_rst", r, 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
